stall_controller: RTL and testbench

//   Central stall/flush sequencer for the 5-stage pipeline (if, id, ex, mem, wb).

---
 rtl/stall_controller.sv | 132 +++++++++++++
 tb/tb_stall_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Merges ID/EX/MEM stall requests into a per-stage hold vector and sequences a
// multi-cycle EX unit through a start/done handshake. A timeout cancels the unit,
// and flush_request aborts any in-flight work.
//
// state | meaning
// IDLE  | no multi-cycle op in flight
// START | launch cycle, ex_unit_start pulses
// BUSY  | unit running, waiting for done or timeout
// DONE  | result available, held while MEM stalls
module stall_controller #(
    parameter int MAX_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_stall_request,
    input  logic       ex_stall_request,
    input  logic       mem_stall_request,
    input  logic       ex_unit_done,
    input  logic       flush_request,
    output logic [5:0] stall,
    output logic       flush,
    output logic       ex_unit_start,
    output logic       ex_unit_cancel,
    output logic       ex_result_valid,
    output logic       timeout_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_CYCLES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               flush_q, flush_nxt;
    logic               cancel_q, cancel_nxt;
    logic               timeout_q;
    logic               timeout_hit;
    logic               ex_term;

    // State, counter and the one-cycle-delayed flush/cancel pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            flush_q   <= 1'b0;
            cancel_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            flush_q  <= flush_nxt;
            cancel_q <= cancel_nxt;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next-state logic; a flush overrides done and timeout.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (ex_stall_request) begin
                    state_nxt = START;
                end
            end
            START: begin
                count_nxt = '0;
                state_nxt = BUSY;
            end
            BUSY: begin
                count_nxt = count + 1'b1;
                if (ex_unit_done) begin
                    state_nxt = DONE;
                end else if (count == LAST_COUNT) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                    count_nxt   = '0;
                end
            end
            DONE: begin
                if (!mem_stall_request) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_request) begin
            state_nxt   = IDLE;
            count_nxt   = '0;
            timeout_hit = 1'b0;
        end
        flush_nxt  = flush_request | timeout_hit;
        cancel_nxt = (flush_request & ((state == START) | (state == BUSY))) | timeout_hit;
    end

    // Stall vector: deepest requester wins; forced clear in a flush cycle or reset.
    always_comb begin
        ex_term = ((state == IDLE) & ex_stall_request) | (state == START) | (state == BUSY)
                | ((state == DONE) & mem_stall_request);
        stall = 6'b000000;
        if (!reset || flush_request) begin
            stall = 6'b000000;
        end else if (mem_stall_request) begin
            stall = 6'b011111;
        end else if (ex_term) begin
            stall = 6'b001111;
        end else if (id_stall_request) begin
            stall = 6'b000111;
        end
    end

    // Handshake outputs; start and result are suppressed by a concurrent flush.
    always_comb begin
        ex_unit_start   = (state == START) & ~flush_request;
        ex_result_valid = (state == DONE) & ~flush_request;
        ex_unit_cancel  = cancel_q;
        flush           = flush_q;
        timeout_error   = timeout_q;
    end

endmodule

// File: tb/tb_stall_controller.sv
// Randomized bench for stall_controller against a cycle-level behavioural model.
module tb_stall_controller;

    localparam int MAX_CYCLES = 34;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       id_stall_request = 1'b0;
    logic       ex_stall_request = 1'b0;
    logic       mem_stall_request = 1'b0;
    logic       ex_unit_done = 1'b0;
    logic       flush_request = 1'b0;
    logic [5:0] stall;
    logic       flush;
    logic       ex_unit_start;
    logic       ex_unit_cancel;
    logic       ex_result_valid;
    logic       timeout_error;

    int checks = 0;
    int errors = 0;

    // Model: an op goes launch -> waiting (counting cycles) -> result held.
    bit launching;
    int wait_cycles;   // -1 when the unit is not running
    bit result_held;
    bit pend_flush;
    bit pend_cancel;
    bit sticky_timeout;
    int timeouts_seen;

    stall_controller #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(6)) dut (
        .clock             (clock),
        .reset             (reset),
        .id_stall_request  (id_stall_request),
        .ex_stall_request  (ex_stall_request),
        .mem_stall_request (mem_stall_request),
        .ex_unit_done      (ex_unit_done),
        .flush_request     (flush_request),
        .stall             (stall),
        .flush             (flush),
        .ex_unit_start     (ex_unit_start),
        .ex_unit_cancel    (ex_unit_cancel),
        .ex_result_valid   (ex_result_valid),
        .timeout_error     (timeout_error)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        launching      = 1'b0;
        wait_cycles    = -1;
        result_held    = 1'b0;
        pend_flush     = 1'b0;
        pend_cancel    = 1'b0;
        sticky_timeout = 1'b0;
    endfunction

    task automatic check_outputs();
        bit   running, idle, ex_hold;
        logic [5:0] exp_stall;
        running = (wait_cycles >= 0);
        idle    = !launching && !running && !result_held;
        ex_hold = (idle && ex_stall_request) || launching || running
                || (result_held && mem_stall_request);
        if (flush_request)          exp_stall = 6'd0;
        else if (mem_stall_request) exp_stall = 6'b011111;
        else if (ex_hold)           exp_stall = 6'b001111;
        else if (id_stall_request)  exp_stall = 6'b000111;
        else                        exp_stall = 6'd0;
        check_val("stall", 32'(stall), 32'(exp_stall));
        check_val("start", 32'(ex_unit_start), 32'(launching && !flush_request));
        check_val("result_valid", 32'(ex_result_valid), 32'(result_held && !flush_request));
        check_val("flush", 32'(flush), 32'(pend_flush));
        check_val("cancel", 32'(ex_unit_cancel), 32'(pend_cancel));
        check_val("timeout_error", 32'(timeout_error), 32'(sticky_timeout));
    endtask

    function automatic void model_clock();
        bit running, idle, timing_out;
        running    = (wait_cycles >= 0);
        idle       = !launching && !running && !result_held;
        timing_out = running && !ex_unit_done && (wait_cycles == MAX_CYCLES - 1) && !flush_request;
        pend_flush  = flush_request || timing_out;
        pend_cancel = (flush_request && (launching || running)) || timing_out;
        if (timing_out) begin
            sticky_timeout = 1'b1;
            timeouts_seen++;
        end
        if (flush_request) begin
            launching   = 1'b0;
            wait_cycles = -1;
            result_held = 1'b0;
        end else if (idle) begin
            if (ex_stall_request) launching = 1'b1;
        end else if (launching) begin
            launching   = 1'b0;
            wait_cycles = 0;
        end else if (running) begin
            if (ex_unit_done) begin
                wait_cycles = -1;
                result_held = 1'b1;
            end else if (timing_out) begin
                wait_cycles = -1;
            end else begin
                wait_cycles++;
            end
        end else if (result_held && !mem_stall_request) begin
            result_held = 1'b0;
        end
    endfunction

    // One cycle: inputs already driven after negedge; check mid-cycle, advance model at posedge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clock);
        if (reset) model_clock();
        else       model_reset();
        @(negedge clock);
    endtask

    initial begin
        int mode;
        int guard;
        model_reset();
        timeouts_seen = 0;
        #2;
        check_val("reset_stall", 32'(stall), 32'd0);
        check_val("reset_flush", 32'(flush), 32'd0);
        check_val("reset_timeout", 32'(timeout_error), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Random traffic; mode 1 withholds done and flush so timeouts occur.
        mode = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 150 == 0) mode = $urandom_range(0, 2);
            id_stall_request  = ($urandom_range(0, 3) == 0);
            ex_stall_request  = ($urandom_range(0, 2) == 0);
            mem_stall_request = ($urandom_range(0, 3) == 0);
            if (mode == 1) begin
                ex_unit_done  = 1'b0;
                flush_request = 1'b0;
            end else begin
                ex_unit_done  = ($urandom_range(0, 5) == 0);
                flush_request = ($urandom_range(0, 40) == 0);
            end
            step();
        end

        // Drive a fresh op into the running phase, then reset asynchronously.
        id_stall_request  = 1'b0;
        mem_stall_request = 1'b0;
        ex_unit_done      = 1'b0;
        flush_request     = 1'b0;
        ex_stall_request  = 1'b1;
        guard = 0;
        while (!(wait_cycles >= 0 && wait_cycles < MAX_CYCLES - 2) && guard < 200) begin
            step();
            guard++;
        end
        check_val("reach_busy_in_budget", 32'(guard < 200), 32'd1);
        id_stall_request  = 1'b1;
        mem_stall_request = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_val("async_rst_stall", 32'(stall), 32'd0);
        check_val("async_rst_cancel", 32'(ex_unit_cancel), 32'd0);
        check_val("async_rst_flush", 32'(flush), 32'd0);
        check_val("async_rst_start", 32'(ex_unit_start), 32'd0);
        check_val("async_rst_valid", 32'(ex_result_valid), 32'd0);
        check_val("async_rst_timeout", 32'(timeout_error), 32'd0);
        model_reset();
        @(negedge clock);
        id_stall_request  = 1'b0;
        ex_stall_request  = 1'b0;
        mem_stall_request = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
